// File: rtl/iiitb_icg_enable_ctrl.sv
// Clock-gate enable controller: synchronizes pad inputs, detects activity and
// drives a registered, glitch-free enable for the downstream integrated clock gate.
module iiitb_icg_enable_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_CYCLES  = 16,
  parameter int DRAIN_CYCLES = 2,
  parameter int GATED_W      = 16
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic               in_async,
  input  logic               d0_async,
  input  logic               d1_async,
  input  logic               force_en,
  input  logic               clr_stat,
  output logic               gate_en,
  output logic               d0_s,
  output logic               d1_s,
  output logic [1:0]         state,
  output logic [GATED_W-1:0] gated_cycles
);

  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IW-1:0] ILOAD = IW'(IDLE_CYCLES - 1);
  localparam logic [DW-1:0] DLOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] in_sync_q, d0_sync_q, d1_sync_q;
  logic                   in_s, d0_sync, d1_sync;
  logic                   d0_p_q, d1_p_q;
  logic                   act;
  state_e                 state_q, state_d;
  logic [IW-1:0]          icnt_q, icnt_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   gate_en_q;
  logic [GATED_W-1:0]     gated_q, gated_d;

  assign in_s    = in_sync_q[SYNC_STAGES-1];
  assign d0_sync = d0_sync_q[SYNC_STAGES-1];
  assign d1_sync = d1_sync_q[SYNC_STAGES-1];

  // Synchronizer chains and previous-value flops for edge detection on d0/d1
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      in_sync_q <= '0;
      d0_sync_q <= '0;
      d1_sync_q <= '0;
      d0_p_q    <= 1'b0;
      d1_p_q    <= 1'b0;
    end else begin
      in_sync_q <= {in_sync_q[SYNC_STAGES-2:0], in_async};
      d0_sync_q <= {d0_sync_q[SYNC_STAGES-2:0], d0_async};
      d1_sync_q <= {d1_sync_q[SYNC_STAGES-2:0], d1_async};
      d0_p_q    <= d0_sync;
      d1_p_q    <= d1_sync;
    end
  end

  assign act = in_s | force_en | (d0_sync ^ d0_p_q) | (d1_sync ^ d1_p_q);

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (act) begin
          state_d = ST_ACTIVE;
          icnt_d  = ILOAD;
        end
      end
      ST_ACTIVE: begin
        if (act) begin
          icnt_d = ILOAD;
        end else if (icnt_q != '0) begin
          icnt_d = icnt_q - IW'(1);
        end else begin
          state_d = ST_DRAIN;
          dcnt_d  = DLOAD;
        end
      end
      ST_DRAIN: begin
        if (act) begin
          state_d = ST_ACTIVE;
          icnt_d  = ILOAD;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The statistic reflects the enable level held during the cycle just ending
  always_comb begin
    gated_d = gated_q;
    if (clr_stat) begin
      gated_d = '0;
    end else if (!gate_en_q && (gated_q != '1)) begin
      gated_d = gated_q + GATED_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      icnt_q    <= '0;
      dcnt_q    <= '0;
      gate_en_q <= 1'b0;
      gated_q   <= '0;
    end else begin
      state_q   <= state_d;
      icnt_q    <= icnt_d;
      dcnt_q    <= dcnt_d;
      gate_en_q <= (state_d != ST_IDLE);
      gated_q   <= gated_d;
    end
  end

  assign gate_en      = gate_en_q;
  assign d0_s         = d0_sync;
  assign d1_s         = d1_sync;
  assign state        = state_q;
  assign gated_cycles = gated_q;

endmodule
